// File: rtl/trng_pkg.sv
// Shared constants, types and sizing helpers for the ring-oscillator sampler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package trng_pkg;

   // Default build-time parameters for the sampler and its synchroniser.
   localparam int DEF_SAMPLE_DIV  = 16;
   localparam int DEF_WORD_W      = 8;
   localparam int DEF_REP_LIMIT   = 32;
   localparam int DEF_SYNC_STAGES = 2;

   // Von Neumann corrector: waiting for the first or the second sample of a pair.
   typedef enum logic {
      VN_FIRST  = 1'b0,
      VN_SECOND = 1'b1
   } vn_state_t;

   // The repetition counter must be able to hold REP_LIMIT itself.
   function automatic int rep_cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/trng_sync.sv
// Multi-flop synchroniser that brings an asynchronous pad bit into the clk domain.
// Latency: STAGES clk cycles from a stable input to o_sync.
// Backpressure: none; the chain free-runs every cycle.
module trng_sync
   import trng_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_chain;

   // Shift the pad bit through the flop chain; the first stage may go metastable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/trng_sampler.sv
// Samples the synchronised RO bit, health-tests it, debiases it and packs words.
// Latency: data_o/valid_o update 1 clk after the strobe that completes a word.
// Backpressure: one output word buffered; a word completing while it is still held is dropped with an overrun_o pulse.
module trng_sampler
   import trng_pkg::*;
#(
   parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
   parameter int WORD_W      = DEF_WORD_W,
   parameter int REP_LIMIT   = DEF_REP_LIMIT,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              raw_in,
   output logic [WORD_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              health_fail_o,
   output logic              overrun_o
);

   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int REP_W = rep_cnt_width(REP_LIMIT);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

   // Synchronised entropy bit
   logic w_sync_bit;

   // Divider
   logic [DIV_W-1:0] r_div_cnt;
   logic             w_strobe;

   // Repetition-count health test
   logic [REP_W-1:0] r_rep_cnt;
   logic             r_prev;
   logic [REP_W-1:0] w_rep_next;
   logic             w_trip;
   logic             w_blocked;
   logic             r_health_fail;

   // Von Neumann corrector
   vn_state_t        r_vn_state;
   logic             r_vn_a;
   logic             w_emit;

   // Packing
   logic [CNT_W-1:0]  r_bit_cnt;
   logic [WORD_W-1:0] r_shift;
   logic [WORD_W-1:0] w_word;
   logic              w_word_done;

   // Output buffer
   logic [WORD_W-1:0] r_data;
   logic              r_valid;
   logic              r_overrun;
   logic              w_xfer;
   logic              w_load;
   logic              w_drop;

   trng_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async (raw_in),
      .o_sync  (w_sync_bit)
   );

   // ---------------------------------------------------------------- divider
   assign w_strobe = en & (r_div_cnt == DIV_LAST);

   // Free-running sample divider, held at zero while sampling is disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div_cnt <= '0;
      end else if (!en || w_strobe) begin
         r_div_cnt <= '0;
      end else begin
         r_div_cnt <= r_div_cnt + DIV_ONE;
      end
   end

   // ------------------------------------------------------------ health test
   // A zero count means no previous sample exists yet, so the next one starts a run of 1.
   always_comb begin
      w_rep_next = r_rep_cnt;
      if (r_rep_cnt == '0 || w_sync_bit != r_prev) begin
         w_rep_next = REP_ONE;
      end else if (r_rep_cnt != REP_MAX) begin
         w_rep_next = r_rep_cnt + REP_ONE;
      end
   end

   // The tripping sample itself is already treated as untrusted.
   assign w_trip    = w_strobe & (w_rep_next == REP_MAX);
   assign w_blocked = r_health_fail | w_trip;

   // Track the current run of identical raw samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rep_cnt <= '0;
         r_prev    <= 1'b0;
      end else if (!en) begin
         r_rep_cnt <= '0;
         r_prev    <= 1'b0;
      end else if (w_strobe) begin
         r_rep_cnt <= w_rep_next;
         r_prev    <= w_sync_bit;
      end
   end

   // Sticky failure flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_health_fail <= 1'b0;
      end else if (w_trip) begin
         r_health_fail <= 1'b1;
      end
   end

   // ------------------------------------------------------ von Neumann stage
   assign w_emit = w_strobe & ~w_blocked & (r_vn_state == VN_SECOND) & (r_vn_a != w_sync_bit);

   // Pair up raw samples: unequal pairs emit their first bit, equal pairs are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vn_state <= VN_FIRST;
         r_vn_a     <= 1'b0;
      end else if (!en || w_blocked) begin
         r_vn_state <= VN_FIRST;
         r_vn_a     <= 1'b0;
      end else if (w_strobe) begin
         if (r_vn_state == VN_FIRST) begin
            r_vn_a     <= w_sync_bit;
            r_vn_state <= VN_SECOND;
         end else begin
            r_vn_state <= VN_FIRST;
         end
      end
   end

   // ---------------------------------------------------------------- packing
   assign w_word_done = w_emit & (r_bit_cnt == BIT_LAST);

   // The completing bit goes straight into the MSB so the word is ready this cycle.
   always_comb begin
      w_word             = r_shift;
      w_word[WORD_W-1]   = r_vn_a;
   end

   // Accumulate emitted bits LSB first; a disabled or failed source discards the partial word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (!en || w_blocked) begin
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else if (w_emit) begin
         if (w_word_done) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end else begin
            r_shift[r_bit_cnt] <= r_vn_a;
            r_bit_cnt          <= r_bit_cnt + CNT_ONE;
         end
      end
   end

   // ---------------------------------------------------------- output buffer
   assign w_xfer = r_valid & ready_i;
   assign w_load = w_word_done & (~r_valid | w_xfer);
   assign w_drop = w_word_done & ~w_load;

   // Single-entry output register; a new word may replace one leaving this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_drop;
         if (w_load) begin
            r_data  <= w_word;
            r_valid <= 1'b1;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o        = r_data;
   assign valid_o       = r_valid;
   assign health_fail_o = r_health_fail;
   assign overrun_o     = r_overrun;

endmodule

// File: tb/tb_trng_sampler.sv
// Scoreboard bench for trng_sampler with a small reference model of the sampler chain.
// Latency: samples are driven one per 4-clk divider period, aligned to enable/reset release.
// Backpressure: ready_i is held low in one scenario to force a held word and an overrun.
module tb_trng_sampler;

   localparam int SAMPLE_DIV  = 4;
   localparam int WORD_W      = 8;
   localparam int REP_LIMIT   = 8;
   localparam int SYNC_STAGES = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              raw_in;
   logic [WORD_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;
   logic              health_fail_o;
   logic              overrun_o;

   trng_sampler #(
      .SAMPLE_DIV  (SAMPLE_DIV),
      .WORD_W      (WORD_W),
      .REP_LIMIT   (REP_LIMIT),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .raw_in        (raw_in),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .health_fail_o (health_fail_o),
      .overrun_o     (overrun_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ reference model
   logic [WORD_W-1:0] sb[$];
   bit                m_fail;
   bit                m_pending;
   bit                m_have_prev;
   bit                m_prev;
   int                m_rep;
   bit                m_second;
   bit                m_a;
   logic [WORD_W-1:0] m_bits;
   int                m_nbits;
   int                m_exp_ovr = 0;
   int                ovr_seen  = 0;
   int                n_xfer    = 0;

   task automatic model_clear(input bit full);
      m_have_prev = 0;
      m_prev      = 0;
      m_rep       = 0;
      m_second    = 0;
      m_a         = 0;
      m_bits      = '0;
      m_nbits     = 0;
      if (full) begin
         m_fail    = 0;
         m_pending = 0;
         sb.delete();
      end
   endtask

   task automatic model_sample(input bit s);
      if (m_fail) return;
      if (m_have_prev && s == m_prev) m_rep++;
      else m_rep = 1;
      m_prev      = s;
      m_have_prev = 1;
      if (m_rep >= REP_LIMIT) begin
         m_fail = 1;
         model_clear(0);
         return;
      end
      if (!m_second) begin
         m_a      = s;
         m_second = 1;
      end else begin
         m_second = 0;
         if (m_a != s) begin
            m_bits[m_nbits] = m_a;
            m_nbits++;
            if (m_nbits == WORD_W) begin
               if (!m_pending) begin
                  sb.push_back(m_bits);
                  m_pending = 1;
               end else begin
                  m_exp_ovr++;
               end
               m_bits  = '0;
               m_nbits = 0;
            end
         end
      end
   endtask

   // Output monitor: compare transferred words and count overrun pulses.
   always begin
      @(negedge clk);
      #1;
      if (overrun_o) ovr_seen++;
      if (valid_o && ready_i) begin
         n_xfer++;
         chk("sb_nonempty", {31'd0, sb.size() > 0}, 1);
         if (sb.size() > 0) chk("word", data_o, sb.pop_front());
         m_pending = 0;
      end
   end

   // ------------------------------------------------------------------ stimulus
   bit seq[$];

   task automatic add_pairs(input bit a, input bit b, input int n);
      for (int i = 0; i < n; i++) begin
         seq.push_back(a);
         seq.push_back(b);
      end
   endtask

   // mode 0: plain; 1: check word latency on last sample; 2: check health flag timing on last sample
   task automatic drive_seq(input int mode);
      for (int i = 0; i < seq.size(); i++) begin
         raw_in = seq[i];
         model_sample(seq[i]);
         if (i == seq.size() - 1 && mode != 0) begin
            repeat (3) @(negedge clk);
            if (mode == 1) chk("valid_early", valid_o, 0);
            else           chk("hf_early", health_fail_o, 0);
            @(negedge clk);
            if (mode == 1) chk("valid_lat", valid_o, 1);
            else           chk("hf_set", health_fail_o, 1);
         end else begin
            repeat (4) @(negedge clk);
         end
      end
      seq.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      model_clear(1);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int xfer_before;
      rst     = 1'b1;
      en      = 1'b0;
      raw_in  = 1'b0;
      ready_i = 1'b1;
      model_clear(1);
      repeat (2) @(negedge clk);
      chk("rst_data", data_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_hf", health_fail_o, 0);
      chk("rst_ovr", overrun_o, 0);

      // 1: (1,0)x8 -> 0xFF, one-cycle valid, 1 clk after 16th strobe
      do_reset();
      en = 1'b1;
      add_pairs(1, 0, 8);
      drive_seq(1);
      @(negedge clk);
      chk("valid_one_clk", valid_o, 0);
      chk("t1_ovr", ovr_seen, m_exp_ovr);

      // 2: (0,1,1,0)x4 -> 0xAA
      do_reset();
      for (int i = 0; i < 4; i++) begin
         add_pairs(0, 1, 1);
         add_pairs(1, 0, 1);
      end
      drive_seq(0);
      repeat (2) @(negedge clk);
      chk("t2_drained", sb.size(), 0);
      chk("t2_data", data_o, 8'hAA);

      // 3: stuck-at-1 trips health test; alternating input afterwards yields nothing
      do_reset();
      for (int i = 0; i < REP_LIMIT; i++) seq.push_back(1);
      drive_seq(2);
      add_pairs(1, 0, 8);
      drive_seq(0);
      chk("t3_no_valid", valid_o, 0);
      chk("t3_hf_model", health_fail_o, m_fail);
      do_reset();
      chk("t3_hf_cleared", health_fail_o, 0);

      // 4: ready low, first word held, second dropped with overrun pulse
      ready_i = 1'b0;
      add_pairs(1, 0, 8);
      drive_seq(0);
      chk("t4_hold_valid", valid_o, 1);
      chk("t4_hold_data", data_o, 8'hFF);
      add_pairs(1, 0, 8);
      drive_seq(0);
      repeat (2) @(negedge clk);
      chk("t4_still_valid", valid_o, 1);
      chk("t4_still_data", data_o, 8'hFF);
      chk("t4_ovr_count", ovr_seen, m_exp_ovr);
      xfer_before = n_xfer;
      ready_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("t4_one_xfer", n_xfer - xfer_before, 1);
      chk("t4_valid_low", valid_o, 0);
      chk("t4_drained", sb.size(), 0);

      // 5: reset mid-word, then (0,1)x8 -> 0x00 with no stale bits
      do_reset();
      add_pairs(1, 0, 5);
      drive_seq(0);
      rst = 1'b1;
      #1;
      chk("t5_rst_data", data_o, 0);
      chk("t5_rst_valid", valid_o, 0);
      chk("t5_rst_hf", health_fail_o, 0);
      chk("t5_rst_ovr", overrun_o, 0);
      do_reset();
      add_pairs(0, 1, 8);
      drive_seq(1);
      repeat (2) @(negedge clk);
      chk("t5_drained", sb.size(), 0);

      // 6: en dropped mid-word, then (1,0)x8 -> 0xFF with divider restarted
      do_reset();
      add_pairs(1, 0, 3);
      drive_seq(0);
      en = 1'b0;
      model_clear(0);
      repeat (5) @(negedge clk);
      en = 1'b1;
      add_pairs(1, 0, 8);
      drive_seq(1);
      repeat (2) @(negedge clk);
      chk("t6_drained", sb.size(), 0);
      chk("final_ovr", ovr_seen, m_exp_ovr);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
